// File: rtl/bpu_pkg.sv
// -----------------------------------------------------------------------------
// bpu_pkg
// Shared types and helpers for the branch commit / BTB training path.
//   branch_commit_t : one resolved branch as presented by the commit stage
//   btb_update_t    : one BTB training write {pc, taken, target}
//   INSN_BYTES      : fall-through stride used for the not-taken fetch PC
//   is_mispredict   : actual outcome vs. fetch-time prediction
//   correct_pc      : fetch PC the front end should have used after a branch
//   to_update       : projects a committed branch onto a BTB training write
// Address fields are sized by BPU_ADDR_WIDTH; modules importing this package
// keep their ADDR_WIDTH parameter equal to it.
// -----------------------------------------------------------------------------
package bpu_pkg;

  localparam int BPU_ADDR_WIDTH = 32;
  localparam int INSN_BYTES     = 4;

  typedef struct packed {
    logic                      valid;
    logic [BPU_ADDR_WIDTH-1:0] pc;
    logic                      taken;
    logic [BPU_ADDR_WIDTH-1:0] target;
    logic                      pred_taken;
    logic [BPU_ADDR_WIDTH-1:0] pred_target;
  } branch_commit_t;

  typedef struct packed {
    logic [BPU_ADDR_WIDTH-1:0] pc;
    logic                      taken;
    logic [BPU_ADDR_WIDTH-1:0] target;
  } btb_update_t;

  // Wrong direction, or right "taken" direction with the wrong target.
  function automatic logic is_mispredict(input branch_commit_t b);
    return (b.taken != b.pred_taken) ||
           (b.taken && b.pred_taken && (b.target != b.pred_target));
  endfunction

  // Taken branches continue at their target, others fall through (wraps).
  function automatic logic [BPU_ADDR_WIDTH-1:0] correct_pc(input branch_commit_t b);
    logic [BPU_ADDR_WIDTH-1:0] pc_v;
    if (b.taken) begin
      pc_v = b.target;
    end else begin
      pc_v = b.pc + BPU_ADDR_WIDTH'(INSN_BYTES);
    end
    return pc_v;
  endfunction

  function automatic btb_update_t to_update(input branch_commit_t b);
    btb_update_t u_v;
    u_v.pc     = b.pc;
    u_v.taken  = b.taken;
    u_v.target = b.target;
    return u_v;
  endfunction

endpackage

// File: rtl/btb_update_fifo.sv
// -----------------------------------------------------------------------------
// btb_update_fifo
// Circular FIFO of btb_update_t accepting up to two pushes and one pop per
// cycle. The head entry is held in its own register so the consumer sees a
// flop-driven entry; an entry pushed into an empty FIFO is visible right
// after the pushing edge.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (empties FIFO)
//   push_cnt[1:0]     number of pushes this cycle (0..2), data_0 goes first
//   push_data_0/1     entries to push
//   pop               consume the head entry (ignored when empty)
//   head_valid        FIFO not empty
//   head_data         oldest entry (zero while empty)
//   count             current occupancy
// Callers must not push beyond DEPTH entries.
// -----------------------------------------------------------------------------
module btb_update_fifo
  import bpu_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       push_cnt,
  input  btb_update_t      push_data_0,
  input  btb_update_t      push_data_1,
  input  logic             pop,
  output logic             head_valid,
  output btb_update_t      head_data,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam btb_update_t      ENTRY_ZERO = {$bits(btb_update_t){1'b0}};

  btb_update_t      mem_r [DEPTH];
  btb_update_t      head_r;
  btb_update_t      head_next_s;
  logic             head_valid_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_next_s;
  logic [PTR_W-1:0] wr_ptr_next_s;
  logic [PTR_W-1:0] wr_ptr_inc_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic [CNT_W-1:0] remain_s;
  logic             pop_s;

  // Next pointers, occupancy and the entry that becomes the head.
  always_comb begin
    pop_s         = pop && (count_r != CNT_ZERO);
    remain_s      = count_r - CNT_W'(pop_s);
    count_next_s  = remain_s + CNT_W'(push_cnt);
    rd_ptr_next_s = rd_ptr_r + PTR_W'(pop_s);
    wr_ptr_next_s = wr_ptr_r + PTR_W'(push_cnt);
    wr_ptr_inc_s  = wr_ptr_r + PTR_W'(1);
    head_next_s   = ENTRY_ZERO;
    // When nothing old survives the pop, the first pushed entry is the head;
    // it is not in mem_r yet, so bypass it.
    if (count_next_s == CNT_ZERO) begin
      head_next_s = ENTRY_ZERO;
    end else if (remain_s == CNT_ZERO) begin
      head_next_s = push_data_0;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // Entry storage; needs no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_cnt != 2'd0) begin
      mem_r[wr_ptr_r] <= push_data_0;
    end
    if (push_cnt == 2'd2) begin
      mem_r[wr_ptr_inc_s] <= push_data_1;
    end
  end

  // Pointers, occupancy and head register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r     <= {PTR_W{1'b0}};
      wr_ptr_r     <= {PTR_W{1'b0}};
      count_r      <= CNT_ZERO;
      head_r       <= ENTRY_ZERO;
      head_valid_r <= 1'b0;
    end else begin
      rd_ptr_r     <= rd_ptr_next_s;
      wr_ptr_r     <= wr_ptr_next_s;
      count_r      <= count_next_s;
      head_r       <= head_next_s;
      head_valid_r <= (count_next_s != CNT_ZERO);
    end
  end

  assign head_valid = head_valid_r;
  assign head_data  = head_r;
  assign count      = count_r;

endmodule

// File: rtl/branch_commit_unit.sv
// -----------------------------------------------------------------------------
// branch_commit_unit
// Commit-side checker of branch predictions. Up to two resolved branches per
// cycle (slot 0 older) are compared against their fetch-time prediction; a
// mispredict raises a registered one-cycle redirect to the correct fetch PC,
// and BTB training writes are queued and drained one per cycle onto the BTB
// update port.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   commit_*_0 / commit_*_1    resolved branch slots (valid, pc, taken,
//                              target, pred_taken, pred_target)
//   commit_ready               at least two free training-queue slots
//   redirect_valid/_pc         mispredict pulse and correct fetch PC
//   update_valid, update_btb_* BTB training write (always accepted)
//   stat_branches/_mispredicts statistics counters
// Optional feature: define BRANCH_STATS_EN to build the statistics counters;
// otherwise both stat ports are tied to zero.
// ADDR_WIDTH must equal bpu_pkg::BPU_ADDR_WIDTH.
// -----------------------------------------------------------------------------
module branch_commit_unit
  import bpu_pkg::*;
#(
  parameter int ADDR_WIDTH  = BPU_ADDR_WIDTH,
  parameter int QUEUE_DEPTH = 8,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  commit_valid_0,
  input  logic [ADDR_WIDTH-1:0] commit_pc_0,
  input  logic                  commit_taken_0,
  input  logic [ADDR_WIDTH-1:0] commit_target_0,
  input  logic                  commit_pred_taken_0,
  input  logic [ADDR_WIDTH-1:0] commit_pred_target_0,
  input  logic                  commit_valid_1,
  input  logic [ADDR_WIDTH-1:0] commit_pc_1,
  input  logic                  commit_taken_1,
  input  logic [ADDR_WIDTH-1:0] commit_target_1,
  input  logic                  commit_pred_taken_1,
  input  logic [ADDR_WIDTH-1:0] commit_pred_target_1,
  output logic                  commit_ready,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  update_valid,
  output logic [ADDR_WIDTH-1:0] update_btb_pc,
  output logic                  update_btb_taken,
  output logic [ADDR_WIDTH-1:0] update_btb_target,
  output logic [CNT_WIDTH-1:0]  stat_branches,
  output logic [CNT_WIDTH-1:0]  stat_mispredicts
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam btb_update_t ENTRY_ZERO = {$bits(btb_update_t){1'b0}};

  branch_commit_t        slot0_s;
  branch_commit_t        slot1_s;
  logic                  acc0_s;
  logic                  acc1_s;
  logic                  mis0_s;
  logic                  mis1_s;
  logic                  live1_s;
  logic                  enq0_s;
  logic                  enq1_s;
  logic [1:0]            push_cnt_s;
  btb_update_t           push_d0_s;
  btb_update_t           push_d1_s;
  logic                  redir_valid_next_s;
  logic [ADDR_WIDTH-1:0] redir_pc_next_s;
  logic [CW-1:0]         fifo_count_s;
  logic [CW-1:0]         count_next_s;
  logic                  head_valid_s;
  btb_update_t           head_s;
  logic                  ready_r;
  logic                  redirect_valid_r;
  logic [ADDR_WIDTH-1:0] redirect_pc_r;

  // Gather each commit slot into a branch record.
  always_comb begin
    slot0_s.valid       = commit_valid_0;
    slot0_s.pc          = commit_pc_0;
    slot0_s.taken       = commit_taken_0;
    slot0_s.target      = commit_target_0;
    slot0_s.pred_taken  = commit_pred_taken_0;
    slot0_s.pred_target = commit_pred_target_0;
    slot1_s.valid       = commit_valid_1;
    slot1_s.pc          = commit_pc_1;
    slot1_s.taken       = commit_taken_1;
    slot1_s.target      = commit_target_1;
    slot1_s.pred_taken  = commit_pred_taken_1;
    slot1_s.pred_target = commit_pred_target_1;
  end

  // Accept, squash, enqueue selection and redirect choice.
  always_comb begin
    acc0_s  = slot0_s.valid && ready_r;
    acc1_s  = slot1_s.valid && ready_r;
    mis0_s  = is_mispredict(slot0_s);
    mis1_s  = is_mispredict(slot1_s);
    // An older mispredict means slot 1 was on the wrong path.
    live1_s = acc1_s && !(acc0_s && mis0_s);
    // Correctly predicted not-taken branches teach the BTB nothing.
    enq0_s  = acc0_s && (slot0_s.taken || mis0_s);
    enq1_s  = live1_s && (slot1_s.taken || mis1_s);

    push_cnt_s = 2'd0;
    push_d0_s  = ENTRY_ZERO;
    push_d1_s  = ENTRY_ZERO;
    // Compact the pushes so the older surviving entry always goes first.
    case ({enq0_s, enq1_s})
      2'b11: begin
        push_cnt_s = 2'd2;
        push_d0_s  = to_update(slot0_s);
        push_d1_s  = to_update(slot1_s);
      end
      2'b10: begin
        push_cnt_s = 2'd1;
        push_d0_s  = to_update(slot0_s);
      end
      2'b01: begin
        push_cnt_s = 2'd1;
        push_d0_s  = to_update(slot1_s);
      end
      default: begin
        push_cnt_s = 2'd0;
      end
    endcase

    redir_valid_next_s = 1'b0;
    redir_pc_next_s    = redirect_pc_r;
    if (acc0_s && mis0_s) begin
      redir_valid_next_s = 1'b1;
      redir_pc_next_s    = correct_pc(slot0_s);
    end else if (live1_s && mis1_s) begin
      redir_valid_next_s = 1'b1;
      redir_pc_next_s    = correct_pc(slot1_s);
    end else begin
      redir_valid_next_s = 1'b0;
      redir_pc_next_s    = redirect_pc_r;
    end

    // The BTB never stalls, so a valid head always pops this cycle.
    count_next_s = fifo_count_s - CW'(head_valid_s) + CW'(push_cnt_s);
  end

  btb_update_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_cnt    (push_cnt_s),
    .push_data_0 (push_d0_s),
    .push_data_1 (push_d1_s),
    .pop         (head_valid_s),
    .head_valid  (head_valid_s),
    .head_data   (head_s),
    .count       (fifo_count_s)
  );

  // Redirect pulse and ready flag, both registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_r          <= 1'b1;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= {ADDR_WIDTH{1'b0}};
    end else begin
      ready_r          <= (count_next_s <= CW'(QUEUE_DEPTH - 2));
      redirect_valid_r <= redir_valid_next_s;
      redirect_pc_r    <= redir_pc_next_s;
    end
  end

  assign commit_ready      = ready_r;
  assign redirect_valid    = redirect_valid_r;
  assign redirect_pc       = redirect_pc_r;
  assign update_valid      = head_valid_s;
  assign update_btb_pc     = head_s.pc;
  assign update_btb_taken  = head_s.taken;
  assign update_btb_target = head_s.target;

`ifdef BRANCH_STATS_EN
  logic [1:0]           n_branches_s;
  logic [CNT_WIDTH-1:0] stat_branches_r;
  logic [CNT_WIDTH-1:0] stat_mispredicts_r;

  // Committed (unsquashed) branches this cycle.
  always_comb begin
    n_branches_s = {1'b0, acc0_s} + {1'b0, live1_s};
  end

  // Wrapping statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches_r    <= {CNT_WIDTH{1'b0}};
      stat_mispredicts_r <= {CNT_WIDTH{1'b0}};
    end else begin
      stat_branches_r    <= stat_branches_r + CNT_WIDTH'(n_branches_s);
      stat_mispredicts_r <= stat_mispredicts_r + CNT_WIDTH'(redir_valid_next_s);
    end
  end

  assign stat_branches    = stat_branches_r;
  assign stat_mispredicts = stat_mispredicts_r;
`else
  assign stat_branches    = {CNT_WIDTH{1'b0}};
  assign stat_mispredicts = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_branch_commit_unit.sv
// Self-checking bench for branch_commit_unit: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_branch_commit_unit;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } upd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid_0, commit_valid_1;
  logic [31:0] commit_pc_0, commit_pc_1;
  logic        commit_taken_0, commit_taken_1;
  logic [31:0] commit_target_0, commit_target_1;
  logic        commit_pred_taken_0, commit_pred_taken_1;
  logic [31:0] commit_pred_target_0, commit_pred_target_1;
  logic        commit_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        update_valid;
  logic [31:0] update_btb_pc;
  logic        update_btb_taken;
  logic [31:0] update_btb_target;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  branch_commit_unit #(
    .ADDR_WIDTH  (32),
    .QUEUE_DEPTH (DEPTH),
    .CNT_WIDTH   (32)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .commit_valid_0       (commit_valid_0),
    .commit_pc_0          (commit_pc_0),
    .commit_taken_0       (commit_taken_0),
    .commit_target_0      (commit_target_0),
    .commit_pred_taken_0  (commit_pred_taken_0),
    .commit_pred_target_0 (commit_pred_target_0),
    .commit_valid_1       (commit_valid_1),
    .commit_pc_1          (commit_pc_1),
    .commit_taken_1       (commit_taken_1),
    .commit_target_1      (commit_target_1),
    .commit_pred_taken_1  (commit_pred_taken_1),
    .commit_pred_target_1 (commit_pred_target_1),
    .commit_ready         (commit_ready),
    .redirect_valid       (redirect_valid),
    .redirect_pc          (redirect_pc),
    .update_valid         (update_valid),
    .update_btb_pc        (update_btb_pc),
    .update_btb_taken     (update_btb_taken),
    .update_btb_target    (update_btb_target),
    .stat_branches        (stat_branches),
    .stat_mispredicts     (stat_mispredicts)
  );

  always #5 clk = ~clk;

  // Reference model state
  upd_t        m_q[$];
  bit          m_ready;
  bit          m_rv;
  logic [31:0] m_rpc;
  logic [31:0] m_br;
  logic [31:0] m_mis;
  bit          blocked;
  bit          saw_not_ready;

  int n_pass   = 0;
  int n_checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit ref_mispredict(bit t, bit pt, logic [31:0] tg, logic [31:0] ptg);
    if (t != pt) return 1'b1;
    if (t && (tg != ptg)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_next_pc(bit t, logic [31:0] pc, logic [31:0] tg);
    return t ? tg : pc + 32'd4;
  endfunction

  task automatic drive0(bit v, logic [31:0] pc, bit t, logic [31:0] tg, bit pt, logic [31:0] ptg);
    commit_valid_0 = v; commit_pc_0 = pc; commit_taken_0 = t;
    commit_target_0 = tg; commit_pred_taken_0 = pt; commit_pred_target_0 = ptg;
  endtask

  task automatic drive1(bit v, logic [31:0] pc, bit t, logic [31:0] tg, bit pt, logic [31:0] ptg);
    commit_valid_1 = v; commit_pc_1 = pc; commit_taken_1 = t;
    commit_target_1 = tg; commit_pred_taken_1 = pt; commit_pred_target_1 = ptg;
  endtask

  task automatic idle();
    drive0(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    drive1(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ready = 1'b1;
    m_rv    = 1'b0;
    m_rpc   = 32'h0;
    m_br    = 32'h0;
    m_mis   = 32'h0;
  endtask

  task automatic check_outputs();
    chk("commit_ready", commit_ready, m_ready);
    chk("redirect_valid", redirect_valid, m_rv);
    if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
    chk("update_valid", update_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      chk("update_btb_pc", update_btb_pc, m_q[0].pc);
      chk("update_btb_taken", update_btb_taken, m_q[0].taken);
      chk("update_btb_target", update_btb_target, m_q[0].target);
    end
`ifdef BRANCH_STATS_EN
    chk("stat_branches", stat_branches, m_br);
    chk("stat_mispredicts", stat_mispredicts, m_mis);
`else
    chk("stat_branches", stat_branches, 32'h0);
    chk("stat_mispredicts", stat_mispredicts, 32'h0);
`endif
  endtask

  // One clock: predict from the current inputs, advance, then compare.
  task automatic tick();
    bit a0, a1, mp0, mp1, live1;
    upd_t e0, e1;
    a0    = commit_valid_0 && m_ready;
    a1    = commit_valid_1 && m_ready;
    mp0   = ref_mispredict(commit_taken_0, commit_pred_taken_0, commit_target_0, commit_pred_target_0);
    mp1   = ref_mispredict(commit_taken_1, commit_pred_taken_1, commit_target_1, commit_pred_target_1);
    live1 = a1 && !(a0 && mp0);
    e0    = '{commit_pc_0, commit_taken_0, commit_target_0};
    e1    = '{commit_pc_1, commit_taken_1, commit_target_1};
    blocked = (commit_valid_0 || commit_valid_1) && !m_ready;
    m_rv = 1'b0;
    if (a0 && mp0) begin
      m_rv  = 1'b1;
      m_rpc = ref_next_pc(e0.taken, e0.pc, e0.target);
    end else if (live1 && mp1) begin
      m_rv  = 1'b1;
      m_rpc = ref_next_pc(e1.taken, e1.pc, e1.target);
    end
    @(posedge clk);
    if (m_q.size() > 0) m_q.delete(0);
    if (a0 && (e0.taken || mp0)) m_q.push_back(e0);
    if (live1 && (e1.taken || mp1)) m_q.push_back(e1);
    m_br  = m_br + 32'(a0) + 32'(live1);
    m_mis = m_mis + 32'(m_rv);
    m_ready = (DEPTH - m_q.size()) >= 2;
    if (!m_ready) saw_not_ready = 1'b1;
    #1;
    check_outputs();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    saw_not_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_commit_ready", commit_ready, 1'b1);
    chk("rst_redirect_valid", redirect_valid, 1'b0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_update_valid", update_valid, 1'b0);
    chk("rst_update_pc", update_btb_pc, 32'h0);
    chk("rst_update_target", update_btb_target, 32'h0);
    chk("rst_stat_branches", stat_branches, 32'h0);
    #3 rst = 1'b0;

    // Taken branch predicted not-taken: redirect to target, train BTB.
    drive0(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    tick();
    chk("tp1_redirect_pc", redirect_pc, 32'h200);
    chk("tp1_update_pc", update_btb_pc, 32'h100);
    idle();
    tick();

    // Slot 0 falsely predicted taken squashes slot 1.
    drive0(1'b1, 32'h140, 1'b0, 32'h500, 1'b1, 32'h500);
    drive1(1'b1, 32'h144, 1'b1, 32'h900, 1'b0, 32'h0);
    tick();
    chk("tp2_redirect_pc", redirect_pc, 32'h144);
    chk("tp2_update_taken", update_btb_taken, 1'b0);
    idle();
    tick();
    chk("tp2_no_second_update", update_valid, 1'b0);

    // Two correct taken branches: two in-order updates, no redirect.
    drive0(1'b1, 32'h300, 1'b1, 32'h400, 1'b1, 32'h400);
    drive1(1'b1, 32'h400, 1'b1, 32'h500, 1'b1, 32'h500);
    tick();
    idle();
    tick();
    chk("tp3_second_update_pc", update_btb_pc, 32'h400);
    tick();

    // Two correct not-taken branches: nothing queued, nothing redirected.
    drive0(1'b1, 32'h600, 1'b0, 32'h0, 1'b0, 32'h0);
    drive1(1'b1, 32'h604, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    idle();
    tick();

    // Back-pressure: keep offering taken pairs, holding them while blocked.
    for (int p = 0, cyc = 0; p < 8 && cyc < 40; cyc++) begin
      drive0(1'b1, 32'h1000 + 32'(p) * 32'h10, 1'b1, 32'h2000 + 32'(p) * 32'h10, 1'b1, 32'h2000 + 32'(p) * 32'h10);
      drive1(1'b1, 32'h1004 + 32'(p) * 32'h10, 1'b1, 32'h3000 + 32'(p) * 32'h10, 1'b1, 32'h3000 + 32'(p) * 32'h10);
      tick();
      if (!blocked) p++;
    end
    chk("tp5_ready_dropped", saw_not_ready, 1'b1);
    idle();
    for (int i = 0; i < 20 && m_q.size() > 5; i++) tick();

    // Asynchronous reset with entries queued.
    #2 rst = 1'b1;
    #1;
    chk("midrst_update_valid", update_valid, 1'b0);
    chk("midrst_commit_ready", commit_ready, 1'b1);
    chk("midrst_redirect_valid", redirect_valid, 1'b0);
    chk("midrst_update_pc", update_btb_pc, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();

    // Randomized traffic with upstream holding blocked slots.
    blocked = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!blocked) begin
        for (int s = 0; s < 2; s++) begin
          bit v, t, pt;
          logic [31:0] pc, tg, ptg;
          v   = ($urandom_range(0, 3) != 0);
          pc  = $urandom & 32'hFFFF_FFFC;
          if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
          t   = $urandom_range(0, 1) == 1;
          tg  = $urandom & 32'hFFFF_FFFC;
          pt  = ($urandom_range(0, 3) != 0) ? t : !t;
          ptg = ($urandom_range(0, 3) != 0) ? tg : ($urandom & 32'hFFFF_FFFC);
          if (s == 0) drive0(v, pc, t, tg, pt, ptg);
          else        drive1(v, pc, t, tg, pt, ptg);
        end
      end
      tick();
    end
    idle();
    repeat (DEPTH + 2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
